// File: rtl/mips32_fetch_if.sv
// Fetch-unit bus: ROM request/response, redirect from execute, and the
// valid/ready instruction stream toward decode.
interface mips32_fetch_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              rom_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              id_valid;
  logic              id_ready;
  logic [ADDR_W-1:0] id_pc;
  logic [DATA_W-1:0] id_inst;

  modport master (
    output rom_en, rom_addr, id_valid, id_pc, id_inst,
    input  rom_data, redirect_valid, redirect_pc, id_ready
  );

  modport slave (
    input  rom_en, rom_addr, id_valid, id_pc, id_inst,
    output rom_data, redirect_valid, redirect_pc, id_ready
  );
endinterface

// File: rtl/mips32_fetch.sv
// Instruction fetch: credit-limited pipelined ROM requests feeding a prefetch
// FIFO of {pc, inst} pairs, with redirect flushing everything in flight.
module mips32_fetch #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 4,
  parameter int                ROM_LAT  = 1,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic            clk,
  input logic            rst,
  mips32_fetch_if.master bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int OCC_W = PTR_W + 3;

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] fifo_pc   [DEPTH];
  logic [DATA_W-1:0] fifo_inst [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic [ROM_LAT-1:0] fl_valid;
  logic [ADDR_W-1:0] fl_pc [ROM_LAT];
  logic [OCC_W-1:0]  in_flight;
  logic [OCC_W-1:0]  occupancy;
  logic              has_head;
  logic              pop;
  logic              push;
  logic              issue;

  always_comb begin
    in_flight = '0;
    for (int i = 0; i < ROM_LAT; i++) begin
      in_flight = in_flight + OCC_W'(fl_valid[i]);
    end
  end

  assign has_head  = (count != '0);
  assign pop       = has_head && bus.id_ready;
  assign push      = fl_valid[ROM_LAT-1];
  // Every outstanding request already owns a FIFO slot, so the FIFO cannot overflow.
  assign occupancy = OCC_W'(count) + in_flight - OCC_W'(pop);
  assign issue     = rst && !bus.redirect_valid && (occupancy < OCC_W'(DEPTH));

  assign bus.rom_en   = issue;
  assign bus.rom_addr = fetch_pc;
  assign bus.id_valid = has_head;
  assign bus.id_pc    = has_head ? fifo_pc[rd_ptr]   : '0;
  assign bus.id_inst  = has_head ? fifo_inst[rd_ptr] : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
      fl_valid <= '0;
      for (int i = 0; i < ROM_LAT; i++) begin
        fl_pc[i] <= '0;
      end
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (bus.redirect_valid) begin
      fetch_pc <= {bus.redirect_pc[ADDR_W-1:2], 2'b00};
      fl_valid <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      fl_valid[0] <= issue;
      fl_pc[0]    <= fetch_pc;
      for (int i = 1; i < ROM_LAT; i++) begin
        fl_valid[i] <= fl_valid[i-1];
        fl_pc[i]    <= fl_pc[i-1];
      end
      if (issue) fetch_pc <= fetch_pc + ADDR_W'(4);
      if (push)  wr_ptr   <= wr_ptr + PTR_W'(1);
      if (pop)   rd_ptr   <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Storage needs no reset: entries are only visible while count covers them.
  always_ff @(posedge clk) begin
    if (push && !bus.redirect_valid) begin
      fifo_pc[wr_ptr]   <= fl_pc[ROM_LAT-1];
      fifo_inst[wr_ptr] <= bus.rom_data;
    end
  end
endmodule
